// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: control packet layout, store
// types, ID/EX stall state and the destination-register rule.
package mips_pkg;

  localparam int CTRL_W            = 12;
  localparam int CTRL_LINK         = 11;
  localparam int CTRL_REG_DST      = 10;
  localparam int CTRL_JUMP         = 9;
  localparam int CTRL_BRANCH       = 8;
  localparam int CTRL_MEM_READ     = 7;
  localparam int CTRL_MEM_TO_REG   = 6;
  localparam int CTRL_MEM_WRITE    = 5;
  localparam int CTRL_ALU_SRC      = 4;
  localparam int CTRL_REG_WRITE    = 3;
  localparam int CTRL_JUMP_REG     = 2;
  localparam int CTRL_SIGN_OR_ZERO = 1;
  localparam int CTRL_SYSCALL      = 0;

  localparam logic [1:0] ST_WORD = 2'd0;
  localparam logic [1:0] ST_HALF = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } stage_state_e;

  // Link writes $ra; otherwise R-type uses rd, I-type uses rt.
  function automatic logic [4:0] dest_reg(
    input logic       link,
    input logic       reg_dst,
    input logic [4:0] rd,
    input logic [4:0] rt
  );
    if (link)
      return REG_RA;
    else if (reg_dst)
      return rd;
    else
      return rt;
  endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// Purely combinational so the forwarding logic can share it.
module id_hazard_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_dst,
  output logic       haz
);

  logic ex_is_load;
  logic field_match;

  assign ex_is_load  = ex_valid & ex_mem_read & ex_reg_write & (ex_dst != 5'd0);
  // Both source fields are compared regardless of instruction format.
  assign field_match = (ex_dst == id_rs) | (ex_dst == id_rt);
  assign haz         = id_valid & ex_is_load & field_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall control and extra stall
// cycles after sub-word loads.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SUBWORD_EXTRA = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [11:0]       ctrl_i,
  input  logic [1:0]        store_type_i,
  input  logic              load_stall_flag_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  output logic              valid_o,
  output logic [11:0]       ctrl_o,
  output logic [1:0]        store_type_o,
  output logic              subword_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        dst_o,
  output logic              stall_o
);

  localparam logic [1:0] EXTRA_RELOAD = (SUBWORD_EXTRA > 0) ? 2'(SUBWORD_EXTRA - 1) : 2'd0;

  stage_state_e      state_reg, state_next;
  logic [1:0]        count_reg, count_next;
  logic              load_bubble, load_id;
  logic              haz;

  logic              valid_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [1:0]        store_type_reg;
  logic              subword_reg;
  logic [DATA_W-1:0] pc_reg, rs_data_reg, rt_data_reg, imm_reg;
  logic [4:0]        rs_reg, rt_reg, dst_reg;

  logic [CTRL_W-1:0] ctrl_next;
  logic [4:0]        dst_next;
  logic [DATA_W-1:0] imm_next;
  logic              unused_opcode;

  assign unused_opcode = ^instr_i[31:26];

  // An empty ID slot must not carry any control bits into EX.
  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
    assign ctrl_next[gi] = valid_i & ctrl_i[gi];
  end

  assign dst_next = dest_reg(ctrl_i[CTRL_LINK], ctrl_i[CTRL_REG_DST],
                             instr_i[15:11], instr_i[20:16]);
  assign imm_next = ctrl_i[CTRL_SIGN_OR_ZERO]
                  ? {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]}
                  : {{(DATA_W-16){1'b0}}, instr_i[15:0]};

  id_hazard_detect u_hazard (
    .id_valid     (valid_i),
    .id_rs        (instr_i[25:21]),
    .id_rt        (instr_i[20:16]),
    .ex_valid     (valid_reg),
    .ex_mem_read  (ctrl_reg[CTRL_MEM_READ]),
    .ex_reg_write (ctrl_reg[CTRL_REG_WRITE]),
    .ex_dst       (dst_reg),
    .haz          (haz)
  );

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    load_bubble = 1'b0;
    load_id     = 1'b0;
    stall_o     = 1'b0;
    if (!rst_n_i) begin
      state_next = RUN;
    end else if (flush_i) begin
      load_bubble = 1'b1;
      state_next  = RUN;
      count_next  = 2'd0;
    end else if (ex_hold_i) begin
      stall_o = 1'b1;
    end else if (state_reg == HOLD) begin
      stall_o     = 1'b1;
      load_bubble = 1'b1;
      if (count_reg == 2'd0)
        state_next = RUN;
      else
        count_next = count_reg - 2'd1;
    end else if (haz) begin
      stall_o     = 1'b1;
      load_bubble = 1'b1;
      // Sub-word loads need extra cycles for alignment before data is usable.
      if (subword_reg && (SUBWORD_EXTRA > 0)) begin
        state_next = HOLD;
        count_next = EXTRA_RELOAD;
      end
    end else begin
      load_id = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= RUN;
      count_reg      <= 2'd0;
      valid_reg      <= 1'b0;
      ctrl_reg       <= '0;
      store_type_reg <= '0;
      subword_reg    <= 1'b0;
      pc_reg         <= '0;
      rs_data_reg    <= '0;
      rt_data_reg    <= '0;
      imm_reg        <= '0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      dst_reg        <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (load_bubble) begin
        valid_reg      <= 1'b0;
        ctrl_reg       <= '0;
        store_type_reg <= '0;
        subword_reg    <= 1'b0;
        pc_reg         <= '0;
        rs_data_reg    <= '0;
        rt_data_reg    <= '0;
        imm_reg        <= '0;
        rs_reg         <= '0;
        rt_reg         <= '0;
        dst_reg        <= '0;
      end else if (load_id) begin
        valid_reg      <= valid_i;
        ctrl_reg       <= ctrl_next;
        store_type_reg <= store_type_i;
        subword_reg    <= load_stall_flag_i;
        pc_reg         <= pc_i;
        rs_data_reg    <= rs_data_i;
        rt_data_reg    <= rt_data_i;
        imm_reg        <= imm_next;
        rs_reg         <= instr_i[25:21];
        rt_reg         <= instr_i[20:16];
        dst_reg        <= dst_next;
      end
    end
  end

  assign valid_o      = valid_reg;
  assign ctrl_o       = ctrl_reg;
  assign store_type_o = store_type_reg;
  assign subword_o    = subword_reg;
  assign pc_o         = pc_reg;
  assign rs_data_o    = rs_data_reg;
  assign rt_data_o    = rt_data_reg;
  assign imm_o        = imm_reg;
  assign rs_o         = rs_reg;
  assign rt_o         = rt_reg;
  assign dst_o        = dst_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage against a cycle-level model of
// the EX slot and remaining-stall count.
module tb_id_ex_stage;

  localparam int EXTRA = 1;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic [11:0] ctrl_i = '0;
  logic [1:0]  store_type_i = '0;
  logic        load_stall_flag_i = 1'b0;
  logic [31:0] rs_data_i = '0;
  logic [31:0] rt_data_i = '0;
  logic        flush_i = 1'b0;
  logic        ex_hold_i = 1'b0;
  logic        valid_o;
  logic [11:0] ctrl_o;
  logic [1:0]  store_type_o;
  logic        subword_o;
  logic [31:0] pc_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_o, rt_o, dst_o;
  logic        stall_o;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .SUBWORD_EXTRA(EXTRA)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .instr_i(instr_i),
    .pc_i(pc_i), .ctrl_i(ctrl_i), .store_type_i(store_type_i),
    .load_stall_flag_i(load_stall_flag_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .flush_i(flush_i), .ex_hold_i(ex_hold_i),
    .valid_o(valid_o), .ctrl_o(ctrl_o), .store_type_o(store_type_o),
    .subword_o(subword_o), .pc_o(pc_o), .rs_data_o(rs_data_o),
    .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o),
    .dst_o(dst_o), .stall_o(stall_o)
  );

  typedef struct {
    bit          full;   // all fields defined (valid instr, bubble, reset)
    logic        valid;
    logic [11:0] ctrl;
    logic [1:0]  st;
    logic        sub;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, dst;
  } slot_t;

  slot_t sb[$];
  slot_t m_ex;
  int    m_extra = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  function automatic slot_t bubble();
    slot_t s = '{default: '0};
    s.full = 1'b1;
    return s;
  endfunction

  // One clock of stimulus; the model predicts stall_o now and the EX slot
  // after the coming edge.
  task automatic step(input logic rstn, input logic v, input logic [31:0] ins,
                      input logic [11:0] c, input logic [1:0] st, input logic lsf,
                      input logic fl, input logic eh, output logic stall_seen);
    slot_t nxt;
    logic  exp_stall;
    logic  uses;
    @(negedge clk);
    rst_n_i = rstn; valid_i = v; instr_i = ins; ctrl_i = c; store_type_i = st;
    load_stall_flag_i = lsf; flush_i = fl; ex_hold_i = eh;
    pc_i = $urandom; rs_data_i = $urandom; rt_data_i = $urandom;
    #1;
    exp_stall = 1'b0;
    nxt = m_ex;
    uses = (m_ex.dst == ins[25:21]) || (m_ex.dst == ins[20:16]);
    if (!rstn) begin
      nxt = bubble(); m_extra = 0;
    end else if (fl) begin
      nxt = bubble(); m_extra = 0;
    end else if (eh) begin
      exp_stall = 1'b1;
    end else if (m_extra > 0) begin
      exp_stall = 1'b1; nxt = bubble(); m_extra--;
    end else if (v && m_ex.valid && m_ex.ctrl[7] && m_ex.ctrl[3] && m_ex.dst != 0 && uses) begin
      exp_stall = 1'b1; nxt = bubble();
      m_extra = m_ex.sub ? EXTRA : 0;
    end else begin
      nxt.full  = v;
      nxt.valid = v;
      nxt.ctrl  = v ? c : 12'h0;
      nxt.st    = st;
      nxt.sub   = lsf;
      nxt.pc    = pc_i;
      nxt.rsd   = rs_data_i;
      nxt.rtd   = rt_data_i;
      nxt.imm   = c[1] ? 32'($signed(ins[15:0])) : {16'h0, ins[15:0]};
      nxt.rs    = ins[25:21];
      nxt.rt    = ins[20:16];
      nxt.dst   = c[11] ? 5'd31 : (c[10] ? ins[15:11] : ins[20:16]);
    end
    stall_seen = stall_o;
    chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
    m_ex = nxt;
    sb.push_back(nxt);
  endtask

  // Present an instruction until it is accepted; returns the stall count.
  task automatic issue(input logic [31:0] ins, input logic [11:0] c,
                       input logic lsf, output int nstall);
    logic s;
    nstall = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, ins, c, 2'd0, lsf, 1'b0, 1'b0, s);
      if (!s) return;
      nstall++;
    end
    chk("issue_bound", {31'b0, s}, 32'd0);
  endtask

  // Monitor: every cycle the DUT presents an EX slot, compare with the queue.
  initial begin
    slot_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("valid", {31'b0, valid_o}, {31'b0, e.valid});
        chk("ctrl", {20'b0, ctrl_o}, {20'b0, e.ctrl});
        if (e.full) begin
          chk("store_type", {30'b0, store_type_o}, {30'b0, e.st});
          chk("subword", {31'b0, subword_o}, {31'b0, e.sub});
          chk("pc", pc_o, e.pc);
          chk("rs_data", rs_data_o, e.rsd);
          chk("rt_data", rt_data_o, e.rtd);
          chk("imm", imm_o, e.imm);
          chk("rs", {27'b0, rs_o}, {27'b0, e.rs});
          chk("rt", {27'b0, rt_o}, {27'b0, e.rt});
          chk("dst", {27'b0, dst_o}, {27'b0, e.dst});
        end
        if (e.valid)
          $display("EX t=%0t pc=%h ctrl=%h dst=%0d imm=%h", $time, pc_o, ctrl_o, dst_o, imm_o);
      end
    end
  end

  localparam logic [31:0] I_ADDIU = 32'h2405FFFF;
  localparam logic [31:0] I_LW    = {6'h23, 5'd1, 5'd8, 16'h0004};
  localparam logic [31:0] I_LBU   = {6'h24, 5'd1, 5'd8, 16'h0001};
  localparam logic [31:0] I_ADD   = {6'h00, 5'd8, 5'd2, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] I_JAL   = 32'h0C000010;
  localparam logic [31:0] I_ANDI  = 32'h30038000;

  initial begin
    int    n;
    logic  s;
    m_ex = bubble();

    repeat (2) step(1'b0, 1'($urandom), $urandom, 12'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), s);

    issue(I_ADDIU, 12'h01A, 1'b0, n);
    @(posedge clk); #2;
    chk("addiu_dst", {27'b0, dst_o}, 32'd5);
    chk("addiu_imm", imm_o, 32'hFFFFFFFF);

    issue(I_LW, 12'h0DC, 1'b0, n);
    issue(I_ADD, 12'h408, 1'b0, n);
    chk("word_stall_len", n, 1);
    @(posedge clk); #2;
    chk("add_rs", {27'b0, rs_o}, 32'd8);

    issue(I_LBU, 12'h0DC, 1'b1, n);
    issue(I_ADD, 12'h408, 1'b0, n);
    chk("subword_stall_len", n, 2);

    // Flush while in the extra sub-word stall cycle.
    issue(I_LBU, 12'h0DC, 1'b1, n);
    step(1'b1, 1'b1, I_ADD, 12'h408, 2'd0, 1'b0, 1'b0, 1'b0, s);
    step(1'b1, 1'b1, I_ADD, 12'h408, 2'd0, 1'b0, 1'b1, 1'b0, s);
    chk("flush_stall", {31'b0, s}, 32'd0);
    @(posedge clk); #2;
    chk("flush_bubble", {31'b0, valid_o}, 32'd0);

    // Back-pressure during a sub-word hazard.
    issue(I_ADDIU, 12'h01A, 1'b0, n);
    issue(I_LBU, 12'h0DC, 1'b1, n);
    step(1'b1, 1'b1, I_ADD, 12'h408, 2'd0, 1'b0, 1'b0, 1'b0, s);
    repeat (3) step(1'b1, 1'b1, I_ADD, 12'h408, 2'd0, 1'b0, 1'b0, 1'b1, s);
    issue(I_ADD, 12'h408, 1'b0, n);
    chk("hold_resume_len", n, 1);

    issue(I_JAL, 12'hB04, 1'b0, n);
    @(posedge clk); #2;
    chk("jal_dst", {27'b0, dst_o}, 32'd31);
    issue(I_ANDI, 12'h018, 1'b0, n);
    @(posedge clk); #2;
    chk("andi_imm", imm_o, 32'h00008000);

    // Random traffic with a small register pool so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      logic [11:0] c;
      ins = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 11'($urandom)};
      c = 12'($urandom);
      if ($urandom_range(0, 1) == 1) c = c | 12'h088;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 85), ins, c,
           2'($urandom), ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 10), s);
    end

    @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
